game_sequencer: RTL



---
 rtl/game_sequencer_if.sv | 34 +++
 rtl/game_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - Frame/control bundle between the game top level and game_sequencer
// Purpose: groups the frame strobe, player/collision inputs and the sequencer status outputs.
// Signals:
//   vsync, start, collision, bonus           - inputs to the sequencer
//   intro_cnt[7:0], start_done, new_wave,    - sequencer outputs
//   game_over, lives[LW-1:0], invulnerable,
//   ship_visible, state[1:0]
// Modports: master = game top level, slave = game_sequencer.
interface game_sequencer_if #(
   parameter int LW = 4
);
   logic          vsync;
   logic          start;
   logic          collision;
   logic          bonus;
   logic [7:0]    intro_cnt;
   logic          start_done;
   logic          new_wave;
   logic          game_over;
   logic [LW-1:0] lives;
   logic          invulnerable;
   logic          ship_visible;
   logic [1:0]    state;

   modport master (
      output vsync, start, collision, bonus,
      input  intro_cnt, start_done, new_wave, game_over, lives, invulnerable, ship_visible, state
   );

   modport slave (
      input  vsync, start, collision, bonus,
      output intro_cnt, start_done, new_wave, game_over, lives, invulnerable, ship_visible, state
   );
endinterface

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - Frame-driven game flow controller (intro, play, respawn, game over)
// Purpose: intro countdown, play/respawn/over state machine, saturating lives counter,
//          post-death invulnerability with ship blink, and one new-wave pulse per game start.
//          All timing is counted in frames on the vsync strobe.
// Ports:
//   clk            - single clock (clk_25)
//   resetN         - asynchronous active-low reset
//   bus (slave)    - vsync/start/collision/bonus in; intro_cnt, start_done, new_wave,
//                    game_over, lives, invulnerable, ship_visible, state out (all registered)
// Optional feature: GAME_SEQ_ATTRACT_EN - OVER restarts by itself after GAMEOVER_FRAMES frames.
module game_sequencer #(
   parameter int INTRO_FRAMES    = 255,
   parameter int NUM_LIVES       = 3,
   parameter int MAX_NUM_LIVES   = 10,
   parameter int RESPAWN_FRAMES  = 120,
   parameter int BLINK_LOG2      = 3,
   parameter int GAMEOVER_FRAMES = 600
) (
   input  logic            clk,
   input  logic            resetN,
   game_sequencer_if.slave bus
);
   localparam int LW     = $clog2(MAX_NUM_LIVES + 1);
   localparam int RW_MIN = $clog2(RESPAWN_FRAMES + 1);
   // The blink bit must exist even for very short respawn windows.
   localparam int RW     = (RW_MIN > BLINK_LOG2 + 1) ? RW_MIN : BLINK_LOG2 + 1;

   localparam logic [LW-1:0] LIVES_INIT = LW'(NUM_LIVES);
   localparam logic [LW-1:0] LIVES_MAX  = LW'(MAX_NUM_LIVES);
   localparam logic [RW-1:0] RESP_LOAD  = RW'(RESPAWN_FRAMES);
   localparam logic [7:0]    INTRO_LAST = 8'(INTRO_FRAMES);

   if (INTRO_FRAMES < 1 || INTRO_FRAMES > 255) begin : g_bad_intro
      $error("game_sequencer: INTRO_FRAMES out of range 1..255");
   end
   if (MAX_NUM_LIVES < NUM_LIVES || NUM_LIVES < 1) begin : g_bad_lives
      $error("game_sequencer: need 1 <= NUM_LIVES <= MAX_NUM_LIVES");
   end
   if (RESPAWN_FRAMES < 1 || GAMEOVER_FRAMES < 1) begin : g_bad_frames
      $error("game_sequencer: RESPAWN_FRAMES and GAMEOVER_FRAMES must be >= 1");
   end

   typedef enum logic [1:0] {
      ST_INTRO   = 2'd0,
      ST_PLAY    = 2'd1,
      ST_RESPAWN = 2'd2,
      ST_OVER    = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    intro_cnt_q, intro_cnt_d;
   logic          start_done_q, start_done_d;
   logic          new_wave_q, new_wave_d;
   logic          game_over_q, game_over_d;
   logic [LW-1:0] lives_q, lives_d;
   logic          invulnerable_q, invulnerable_d;
   logic          ship_visible_q, ship_visible_d;
   logic [RW-1:0] resp_cnt_q, resp_cnt_d;
   logic          wave_arm_q, wave_arm_d;
   logic          start_prev_q, start_prev_d;
   logic          bonus_prev_q, bonus_prev_d;

   logic          start_rise;
   logic          bonus_rise;
   logic [LW-1:0] lives_bonus;
   logic          restart;

`ifdef GAME_SEQ_ATTRACT_EN
   localparam int AW = $clog2(GAMEOVER_FRAMES + 1);
   logic [AW-1:0] attract_cnt_q, attract_cnt_d;
`endif

   assign start_rise   = bus.start & ~start_prev_q;
   assign bonus_rise   = bus.bonus & ~bonus_prev_q;
   assign start_prev_d = bus.start;
   assign bonus_prev_d = bus.bonus;
   // Lives after a bonus, held at the ceiling.
   assign lives_bonus  = (lives_q < LIVES_MAX) ? lives_q + LW'(1) : LIVES_MAX;

   always_comb begin
      state_d      = state_q;
      intro_cnt_d  = intro_cnt_q;
      start_done_d = start_done_q;
      new_wave_d   = 1'b0;
      lives_d      = lives_q;
      resp_cnt_d   = resp_cnt_q;
      wave_arm_d   = wave_arm_q;
      restart      = 1'b0;
`ifdef GAME_SEQ_ATTRACT_EN
      attract_cnt_d = '0;
`endif

      case (state_q)
         ST_INTRO: begin
            if (bus.vsync) begin
               if (intro_cnt_q < INTRO_LAST) begin
                  intro_cnt_d = intro_cnt_q + 8'd1;
               end else begin
                  state_d      = ST_PLAY;
                  start_done_d = 1'b1;
                  wave_arm_d   = 1'b1;
               end
            end
         end
         ST_PLAY: begin
            if (bus.vsync && wave_arm_q) begin
               new_wave_d = 1'b1;
               wave_arm_d = 1'b0;
            end
            if (bus.collision) begin
               if (bonus_rise) begin
                  // Bonus cancels the loss; only a count already at the ceiling drops,
                  // and the ship always respawns even on its last life.
                  lives_d    = lives_bonus - LW'(1);
                  state_d    = ST_RESPAWN;
                  resp_cnt_d = RESP_LOAD;
               end else if (lives_q > LW'(1)) begin
                  lives_d    = lives_q - LW'(1);
                  state_d    = ST_RESPAWN;
                  resp_cnt_d = RESP_LOAD;
               end else begin
                  lives_d = '0;
                  state_d = ST_OVER;
               end
            end else if (bonus_rise) begin
               lives_d = lives_bonus;
            end
         end
         ST_RESPAWN: begin
            if (bonus_rise) begin
               lives_d = lives_bonus;
            end
            if (bus.vsync) begin
               resp_cnt_d = resp_cnt_q - RW'(1);
               if (resp_cnt_q == RW'(1)) begin
                  state_d = ST_PLAY;
               end
            end
         end
         ST_OVER: begin
`ifdef GAME_SEQ_ATTRACT_EN
            attract_cnt_d = attract_cnt_q;
            if (bus.vsync) begin
               if (attract_cnt_q == AW'(GAMEOVER_FRAMES - 1)) begin
                  restart = 1'b1;
               end else begin
                  attract_cnt_d = attract_cnt_q + AW'(1);
               end
            end
`endif
            if (start_rise) begin
               restart = 1'b1;
            end
         end
         default: state_d = ST_INTRO;
      endcase

      if (restart) begin
         state_d      = ST_INTRO;
         lives_d      = LIVES_INIT;
         intro_cnt_d  = '0;
         start_done_d = 1'b0;
`ifdef GAME_SEQ_ATTRACT_EN
         attract_cnt_d = '0;
`endif
      end

      // Status flags follow the next state so they line up with it on the outputs.
      game_over_d    = (state_d == ST_OVER);
      invulnerable_d = (state_d == ST_RESPAWN);
      if (state_d == ST_OVER) begin
         ship_visible_d = 1'b0;
      end else if (state_d == ST_RESPAWN) begin
         ship_visible_d = ~resp_cnt_d[BLINK_LOG2];
      end else begin
         ship_visible_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q        <= ST_INTRO;
         intro_cnt_q    <= '0;
         start_done_q   <= 1'b0;
         new_wave_q     <= 1'b0;
         game_over_q    <= 1'b0;
         lives_q        <= LIVES_INIT;
         invulnerable_q <= 1'b0;
         ship_visible_q <= 1'b1;
         resp_cnt_q     <= '0;
         wave_arm_q     <= 1'b0;
         start_prev_q   <= 1'b0;
         bonus_prev_q   <= 1'b0;
`ifdef GAME_SEQ_ATTRACT_EN
         attract_cnt_q  <= '0;
`endif
      end else begin
         state_q        <= state_d;
         intro_cnt_q    <= intro_cnt_d;
         start_done_q   <= start_done_d;
         new_wave_q     <= new_wave_d;
         game_over_q    <= game_over_d;
         lives_q        <= lives_d;
         invulnerable_q <= invulnerable_d;
         ship_visible_q <= ship_visible_d;
         resp_cnt_q     <= resp_cnt_d;
         wave_arm_q     <= wave_arm_d;
         start_prev_q   <= start_prev_d;
         bonus_prev_q   <= bonus_prev_d;
`ifdef GAME_SEQ_ATTRACT_EN
         attract_cnt_q  <= attract_cnt_d;
`endif
      end
   end

   assign bus.state        = state_q;
   assign bus.intro_cnt    = intro_cnt_q;
   assign bus.start_done   = start_done_q;
   assign bus.new_wave     = new_wave_q;
   assign bus.game_over    = game_over_q;
   assign bus.lives        = lives_q;
   assign bus.invulnerable = invulnerable_q;
   assign bus.ship_visible = ship_visible_q;
endmodule
